// File: rtl/gate_truth_checker.sv
// ---------------------------------------------------------------------------
// gate_truth_checker
//
// Self-test engine for a 2-input combinational gate. Sweeps the stimulus
// {a,b} = 00, 01, 10, 11, holds each vector for HOLD_CYCLES clocks, samples
// the gate response on the last edge of each hold window and compares it with
// a truth table latched at launch. Reports a per-vector fail mask and an
// overall pass flag once the sweep completes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      launch request, honoured only when idle
//   exp_table  expected truth table, bit i = expected out for {a,b} = i
//   gate_out   response of the gate under test
//   gate_a     stimulus a
//   gate_b     stimulus b
//   vec_idx    index of the vector currently applied ({gate_a,gate_b})
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a sweep completes
//   pass       last completed sweep had no mismatches
//   fail_mask  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module gate_truth_checker #(
   parameter int HOLD_CYCLES = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] exp_table,
   input  logic       gate_out,
   output logic       gate_a,
   output logic       gate_b,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [1:0]       vec_idx_q,   vec_idx_d;
   logic [3:0]       table_q,     table_d;
   logic [3:0]       fail_mask_q, fail_mask_d;
   logic             pass_q,      pass_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             gate_a_q,    gate_a_d;
   logic             gate_b_q,    gate_b_d;

   logic             sample;
   logic             mismatch;
   logic [3:0]       mask_upd;

   // Mask including the result of the vector being sampled on this edge, so
   // the final pass flag can be registered on the same edge as the last sample.
   assign sample   = (cnt_q == CNT_LAST);
   assign mismatch = (gate_out != table_q[vec_idx_q]);
   assign mask_upd = fail_mask_q | ({3'b000, mismatch} << vec_idx_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vec_idx_d   = vec_idx_q;
      table_d     = table_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      busy_d      = busy_q;
      done_d      = done_q;
      gate_a_d    = gate_a_q;
      gate_b_d    = gate_b_q;

      case (state_q)
         ST_IDLE: begin
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
            busy_d   = 1'b0;
            if (start) begin
               table_d     = exp_table;
               fail_mask_d = 4'b0000;
               pass_d      = 1'b0;
               vec_idx_d   = 2'd0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               state_d     = ST_APPLY;
            end
         end

         ST_APPLY: begin
            if (sample) begin
               fail_mask_d = mask_upd;
               cnt_d       = '0;
               if (vec_idx_q != 2'd3) begin
                  vec_idx_d            = vec_idx_q + 2'd1;
                  {gate_a_d, gate_b_d} = vec_idx_q + 2'd1;
               end else begin
                  state_d   = ST_DONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  gate_a_d  = 1'b0;
                  gate_b_d  = 1'b0;
                  vec_idx_d = 2'd0;
                  pass_d    = (mask_upd == 4'b0000);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            // start is deliberately not looked at here: no queuing.
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         vec_idx_q   <= 2'd0;
         table_q     <= 4'b0000;
         fail_mask_q <= 4'b0000;
         pass_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_idx_q   <= vec_idx_d;
         table_q     <= table_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         gate_a_q    <= gate_a_d;
         gate_b_q    <= gate_b_d;
      end
   end

   assign gate_a    = gate_a_q;
   assign gate_b    = gate_b_q;
   assign vec_idx   = vec_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Synthesizable self-test engine for any 2-input combinational gate. It drives the exhaustive stimulus sweep {a,b} = 00, 01, 10, 11 into a gate under test and holds each vector for a fixed number of cycles. It samples the gate's output and compares it against a 4-entry expected truth table, then reports a per-vector fail mask and an overall pass flag. It sits beside gate instances in hardware self-test builds: it generates the stimulus and checks the response that the simulation benches otherwise handle.

Parameters:
HOLD_CYCLES, 10, clock cycles each vector is driven before its response is sampled; legal range >= 1.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  launch request; honoured only in IDLE.
exp_table  input  4  expected truth table; bit i = expected out for vector {a,b} = i; captured on accepted start.
gate_out  input  1  output of gate under test; same clock domain, no synchroniser.
gate_a  output  1  stimulus a to gate under test.
gate_b  output  1  stimulus b to gate under test.
vec_idx  output  2  index of vector currently applied ({gate_a,gate_b}).
busy  output  1  high while a sweep is in progress.
done  output  1  single-cycle pulse when sweep completes.
pass  output  1  1 when last completed sweep had fail_mask == 0; held until next accepted start.
fail_mask  output  4  bit i set if vector i mismatched; held until next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately): state = IDLE; gate_a, gate_b, vec_idx, busy, done, pass, fail_mask, hold counter, latched table all 0.
- FSM states: IDLE, APPLY, DONE.
- IDLE: gate_a = gate_b = 0, busy = 0. On an edge with start = 1: latch exp_table; clear fail_mask and pass; vec_idx = 0; cnt = 0; busy = 1; go to APPLY.
- APPLY: {gate_a,gate_b} = vec_idx, registered. cnt increments each edge.
- Sample edge is the edge where cnt == HOLD_CYCLES-1. At that edge, if gate_out != latched_table[vec_idx], set fail_mask[vec_idx].
- At the sample edge, if vec_idx < 3: vec_idx += 1 and cnt = 0.
- At the sample edge, if vec_idx == 3: go to DONE, busy = 0, done = 1, gate_a = gate_b = 0, vec_idx = 0.
- Each vector is driven for exactly HOLD_CYCLES cycles.
- DONE: lasts one cycle. pass = (fail_mask == 0), registered so it is valid from the DONE cycle onward. Next edge: done = 0, return to IDLE.
- Timing: with start accepted at edge E0, the samples occur at E0 + k*HOLD_CYCLES for k = 1..4. done is high for the cycle following E0 + 4*HOLD_CYCLES.
- Widths: cnt width = $clog2(HOLD_CYCLES+1) bits minimum. vec_idx increments only from 0 to 3 and never wraps inside a sweep.
- start while busy or in DONE is ignored; there is no queuing.
- A start held high continuously relaunches on the first IDLE edge after DONE, giving back-to-back sweeps with one idle-free gap.
- exp_table changes mid-sweep have no effect; only the latched copy is used.
- gate_out is sampled only at sample edges; glitches elsewhere are irrelevant.
- Reset mid-sweep aborts immediately with no done pulse. pass and fail_mask read 0 afterwards.

Test Plan:
1. Default HOLD_CYCLES=10, OR gate connected, exp_table=4'b1110, start pulsed at edge E0. Required: vectors 00, 01, 10, 11 each held 10 cycles; done pulse in cycle after E0+40; pass=1; fail_mask=4'b0000.
2. OR gate connected, exp_table=4'b1000 (AND table). Required: fail_mask=4'b0110, pass=0; done timing as in scenario 1.
3. gate_out tied to 0, exp_table=4'b1110. Required: fail_mask=4'b1110, pass=0. Follow with gate_out tied to 1, exp_table=4'b1111: pass=1, and the new start has cleared the previous mask.
4. Pulse start at cycles 5 and 20 after a launch, and change exp_table to 4'b0000 mid-sweep, OR gate, original exp_table=4'b1110. Required: exactly one done pulse, pass=1. Then hold start high: a second sweep begins on the IDLE edge right after DONE.
5. Assert rst_n low asynchronously while vec_idx=2 (mid-hold). Required: busy, gate_a, gate_b, vec_idx, fail_mask, pass go 0 without waiting for a clock edge; no done pulse. After release, start runs a clean sweep with correct results.
6. HOLD_CYCLES=1, OR gate, exp_table=4'b1110. Required: the vector changes every cycle (00, 01, 10, 11); done high in the cycle after E0+4; pass=1.
